// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle mul/div sequencer driving ALU phase and divider strobes
module muldiv_seq #(
  parameter int DIV_ITERS = 32,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [20:0] alu_op,
  input  logic        kill,
  output logic [1:0]  mul_state,
  output logic        d_init,
  output logic        d_advance,
  output logic        div_last,
  output logic        stall,
  output logic        md_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] MUL1    = 3'd1;
  localparam logic [2:0] MUL2    = 3'd2;
  localparam logic [2:0] DIV_RUN = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_ITERS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_mul;

  logic is_mul;
  logic is_div;
  logic start;
  logic unused_alu_bits;

  assign is_mul = |alu_op[13:10];
  assign is_div = |alu_op[17:14];
  // resetn gates start so the Mealy start outputs also stay low while reset is held
  assign start  = resetn & op_valid & (is_mul | is_div) & ~kill;
  assign unused_alu_bits = ^{alu_op[20:18], alu_op[9:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_mul <= 1'b0;
    end else if (kill) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_mul <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_div) begin
              state   <= DIV_RUN;
              cnt     <= CNT_INIT;
              lat_mul <= 1'b0;
            end else begin
              state   <= MUL1;
              lat_mul <= 1'b1;
            end
          end
        end
        MUL1: state <= MUL2;
        MUL2: state <= DONE;
        DIV_RUN: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          lat_mul <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          lat_mul <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mul_state = 2'b00;
    d_init    = 1'b0;
    d_advance = 1'b0;
    div_last  = 1'b0;
    stall     = 1'b0;
    md_done   = 1'b0;
    if (!kill) begin
      case (state)
        IDLE: begin
          if (start) begin
            stall  = 1'b1;
            d_init = is_div;
          end
        end
        MUL1: begin
          mul_state = 2'b01;
          stall     = 1'b1;
        end
        MUL2: begin
          mul_state = 2'b10;
          stall     = 1'b1;
        end
        DIV_RUN: begin
          d_advance = 1'b1;
          stall     = 1'b1;
          div_last  = (cnt == '0);
        end
        DONE: begin
          md_done   = 1'b1;
          mul_state = lat_mul ? 2'b11 : 2'b00;
        end
        default: begin
          mul_state = 2'b00;
        end
      endcase
    end
  end

endmodule
